gb_cart_loader: RTL and testbench
=================================

# gb_cart_loader

Download-side loader for the Game Boy core, sitting between the HPS ioctl download stream and the SDRAM controller's write port. It accepts 16-bit ROM words from the HPS and paces them into SDRAM on the `ce_cpu` slot strobe, back-pressuring the HPS with `ioctl_wait`. While words stream past, it captures the cartridge header, verifies the header checksum, and derives the ROM/RAM bank masks that the MBC mapper consumes. It raises `cart_ready` once the image has been fully written.

## Interface

Parameters:
- `IOCTL_AW`, default 25: ioctl byte-address width.
- `MEM_AW`, default 24: SDRAM word-address width; must equal `IOCTL_AW-1`.

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ce_cpu` in 1: SDRAM slot strobe, one `clk_sys` cycle in every 8.
- `ioctl_download` in 1: high for the whole download.
- `ioctl_wr` in 1: one-cycle word-valid pulse.
- `ioctl_addr` in `IOCTL_AW`: byte address of the word; bit 0 is always 0.
- `ioctl_dout` in 16: word data. The low byte is the even address; the high byte is the odd address.
- `ioctl_wait` out 1: HPS must not pulse `ioctl_wr` while this is high.
- `mem_addr` out `MEM_AW`: SDRAM word address (`ioctl_addr[IOCTL_AW-1:1]`).
- `mem_din` out 16: SDRAM write data.
- `mem_we` out 1: SDRAM write request, sampled by the controller on `ce_cpu`.
- `cart_ready` out 1: image loaded; gates cart reads.
- `cart_mbc_type` out 8: header byte 0x147.
- `cart_rom_size` out 8: header byte 0x148.
- `cart_ram_size` out 8: header byte 0x149.
- `rom_mask` out 7: ROM bank mask.
- `ram_mask` out 2: RAM bank mask.
- `hdr_chk_ok` out 1: header checksum matched byte 0x14D.

## Operation

- All outputs are registered.
- Reset values: all outputs are 0, and the FSM is in IDLE.
- FSM states and transitions:
  - **IDLE**: on `ioctl_wr & ioctl_download`:
    - latch the address and data;
    - set `ioctl_wait` = 1;
    - go to PEND.
  - **PEND**: on `ce_cpu`:
    - set `mem_we` = 1;
    - go to WRITE.
  - **WRITE**: on the next `ce_cpu`, which is the strobe at which the controller samples the write:
    - set `mem_we` = 0 and `ioctl_wait` = 0;
    - go to IDLE.
- `ioctl_wr` outside IDLE is a protocol violation and is ignored.
- Download start (rising edge of `ioctl_download`): clears `cart_ready`, the header registers, the masks, `hdr_chk_ok` and the checksum accumulator.
- Download end (`ioctl_download` low while in IDLE, after a rising edge has been seen): sets `cart_ready` = 1 and holds it until the next download or reset.
  - If `ioctl_download` falls during PEND or WRITE, the write completes and `cart_ready` rises on the cycle after the FSM returns to IDLE.
- Header capture happens on accepted words:
  - word at 0x146: `cart_mbc_type` ← `dout[15:8]`;
  - word at 0x148: `cart_rom_size` ← `dout[7:0]` and `cart_ram_size` ← `dout[15:8]`.
- Header checksum uses an 8-bit accumulator `x`, initially 0, with all arithmetic mod 256:
  - each word from 0x134 to 0x14A: `x ← x − lo − hi − 2`;
  - word 0x14C: `hdr_chk_ok ← ((x − lo − 1) == hi)`.
- Masks are combinational from the header registers, then registered:
  - `rom_mask` = `(2 << rom_size) − 1` truncated to 7 bits for `rom_size` ≤ 6, else 7'h7F. Size 0 gives 7'b0000001.
  - `ram_mask` = 2'b11 if `ram_size` == 3, else 2'b00.
- `reset` mid-write aborts the transfer: FSM to IDLE, `ioctl_wait` = 0, `mem_we` = 0. The SDRAM word may be partially written; the HPS restarts the download.

## Timing

- `ioctl_wr` at cycle t gives `ioctl_wait` = 1 and `mem_addr`/`mem_din` valid at t+1.
- `mem_we` rises the cycle after the first `ce_cpu` at or after t+1. It stays high for exactly 8 cycles and covers exactly one `ce_cpu` strobe.
- `ioctl_wait` falls in the same cycle that `mem_we` falls. Worst-case occupancy per word is 17 cycles.
- Header registers and `hdr_chk_ok` update at t+1 of the accepting cycle; the masks update at t+2.
- `mem_addr` and `mem_din` stay stable from t+1 until the FSM leaves WRITE.

## Test plan

- **Reset:** hold `reset` 3 cycles mid-PEND → all outputs 0, FSM back in IDLE, no `mem_we` pulse afterwards.
- **Single word:** word 0xBEEF at byte address 0x000010 → `mem_addr` = 0x000008, `mem_din` = 0xBEEF. `mem_we` is high across exactly one `ce_cpu`, and `ioctl_wait` is high from t+1 until `mem_we` falls.
- **Header capture:** stream 0x0000–0x014F with 0x146 = 0x0300 and 0x148 = 0x0305:
  - `cart_mbc_type` = 0x03, `cart_rom_size` = 0x05, `cart_ram_size` = 0x03;
  - `rom_mask` = 7'h3F, `ram_mask` = 2'b11.
- **Checksum:** bytes 0x134–0x14C all 0x00 with 0x14D = 0xE7 → `hdr_chk_ok` = 1. The same image with 0x14D = 0xE6 → `hdr_chk_ok` = 0.
- **Download end mid-write:** drop `ioctl_download` while in WRITE → the write completes, and `cart_ready` rises the cycle after IDLE is reached. A new rising edge of `ioctl_download` clears `cart_ready` and all header outputs.
- **Illegal strobe:** pulse `ioctl_wr` with a second word while in PEND → the second word is ignored, SDRAM gets only the first word, and the FSM returns to IDLE after one write.

Source files
------------

// File: rtl/gb_cart_loader.sv
// Download-side cartridge loader: paces HPS ioctl words into the SDRAM write slot
// and extracts header fields, header checksum status and bank masks in passing.
module gb_cart_loader #(
  parameter int IOCTL_AW = 25,
  parameter int MEM_AW   = 24
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_cpu,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [15:0]         ioctl_dout,
  output logic                ioctl_wait,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [15:0]         mem_din,
  output logic                mem_we,
  output logic                cart_ready,
  output logic [7:0]          cart_mbc_type,
  output logic [7:0]          cart_rom_size,
  output logic [7:0]          cart_ram_size,
  output logic [6:0]          rom_mask,
  output logic [1:0]          ram_mask,
  output logic                hdr_chk_ok
);

  // state | meaning
  // IDLE  | ready for an ioctl word; signals end of download
  // PEND  | word latched, waiting for a ce_cpu slot to raise mem_we
  // WRITE | mem_we high, waiting for the ce_cpu slot that samples the write

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [IOCTL_AW-1:0] ADDR_MBC       = IOCTL_AW'(32'h146);
  localparam logic [IOCTL_AW-1:0] ADDR_SIZE      = IOCTL_AW'(32'h148);
  localparam logic [IOCTL_AW-1:0] ADDR_CHK_FIRST = IOCTL_AW'(32'h134);
  localparam logic [IOCTL_AW-1:0] ADDR_CHK_LAST  = IOCTL_AW'(32'h14A);
  localparam logic [IOCTL_AW-1:0] ADDR_CHK_WORD  = IOCTL_AW'(32'h14C);

  state_t     state;
  logic       dl_prev;
  logic       dl_seen;
  logic [7:0] chk_acc;

  logic       dl_rise;
  logic       accept;
  logic [7:0] dout_lo;
  logic [7:0] dout_hi;
  logic [7:0] chk_base;
  logic [7:0] chk_next;
  logic [7:0] chk_final;
  logic [6:0] rom_mask_next;
  logic [1:0] ram_mask_next;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign accept  = (state == IDLE) & ioctl_wr & ioctl_download;
  assign dout_lo = ioctl_dout[7:0];
  assign dout_hi = ioctl_dout[15:8];

  // a word accepted on the download's first cycle must see a cleared accumulator
  assign chk_base  = dl_rise ? 8'd0 : chk_acc;
  assign chk_next  = chk_base - dout_lo - dout_hi - 8'd2;
  assign chk_final = chk_base - dout_lo - 8'd1;

  always_comb begin
    rom_mask_next = 7'h7F;
    if (cart_rom_size <= 8'd6) begin
      rom_mask_next = 7'((8'd2 << cart_rom_size[2:0]) - 8'd1);
    end
    ram_mask_next = (cart_ram_size == 8'd3) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      dl_prev       <= 1'b0;
      dl_seen       <= 1'b0;
      chk_acc       <= 8'd0;
      ioctl_wait    <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= 16'd0;
      mem_we        <= 1'b0;
      cart_ready    <= 1'b0;
      cart_mbc_type <= 8'd0;
      cart_rom_size <= 8'd0;
      cart_ram_size <= 8'd0;
      rom_mask      <= 7'd0;
      ram_mask      <= 2'd0;
      hdr_chk_ok    <= 1'b0;
    end else begin
      dl_prev  <= ioctl_download;
      rom_mask <= rom_mask_next;
      ram_mask <= ram_mask_next;

      if (dl_rise) begin
        dl_seen       <= 1'b1;
        cart_ready    <= 1'b0;
        cart_mbc_type <= 8'd0;
        cart_rom_size <= 8'd0;
        cart_ram_size <= 8'd0;
        rom_mask      <= 7'd0;
        ram_mask      <= 2'd0;
        hdr_chk_ok    <= 1'b0;
        chk_acc       <= 8'd0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr   <= ioctl_addr[IOCTL_AW-1:1];
            mem_din    <= ioctl_dout;
            ioctl_wait <= 1'b1;
            state      <= PEND;
            if (ioctl_addr == ADDR_MBC) begin
              cart_mbc_type <= dout_hi;
            end
            if (ioctl_addr == ADDR_SIZE) begin
              cart_rom_size <= dout_lo;
              cart_ram_size <= dout_hi;
            end
            if ((ioctl_addr >= ADDR_CHK_FIRST) && (ioctl_addr <= ADDR_CHK_LAST)) begin
              chk_acc <= chk_next;
            end
            if (ioctl_addr == ADDR_CHK_WORD) begin
              hdr_chk_ok <= (chk_final == dout_hi);
            end
          end else if (!ioctl_download && dl_seen) begin
            cart_ready <= 1'b1;
          end
        end
        PEND: begin
          if (ce_cpu) begin
            mem_we <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (ce_cpu) begin
            mem_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          mem_we     <= 1'b0;
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cart_loader.sv
// Bench for gb_cart_loader: a schedule-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gb_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_cpu = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        cart_ready;
  logic [7:0]  cart_mbc_type;
  logic [7:0]  cart_rom_size;
  logic [7:0]  cart_ram_size;
  logic [6:0]  rom_mask;
  logic [1:0]  ram_mask;
  logic        hdr_chk_ok;

  gb_cart_loader #(.IOCTL_AW(25), .MEM_AW(24)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .cart_ready(cart_ready), .cart_mbc_type(cart_mbc_type),
    .cart_rom_size(cart_rom_size), .cart_ram_size(cart_ram_size),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .hdr_chk_ok(hdr_chk_ok)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ce_cpu is high for the clock edges whose index is 7 mod 8
  function automatic bit ce_at(input int n);
    return (n % 8) == 7;
  endfunction

  initial forever begin
    @(posedge clk_sys); #2;
    ce_cpu = ce_at(cyc + 1);
  end

  function automatic logic [6:0] exp_rom_mask(input logic [7:0] rs);
    int v;
    if (rs > 8'd6) return 7'h7F;
    v = (2 << rs) - 1;
    return v[6:0];
  endfunction

  // reference model: timing as windows of edge indices, header as plain byte math
  int          m_acc_t = 0, m_we_lo = 0, m_hi = 0, m_busy_end = 0;
  bit          m_prev_dl = 0, m_seen = 0, m_ready = 0, m_ok = 0;
  logic [7:0]  m_mbc = 0, m_rom = 0, m_ram = 0, m_x = 0;
  logic [6:0]  m_rmask = 0;
  logic [1:0]  m_amask = 0;
  logic [23:0] m_addr = 0;
  logic [15:0] m_din = 0;

  // observed SDRAM writes: a write lands when ce_cpu is sampled with mem_we high
  int          wr_count = 0, run_len = 0, last_len = 0;
  logic        s_we = 0;
  logic [23:0] s_addr = 0, w_addr = 0;
  logic [15:0] s_din = 0, w_din = 0;

  initial forever begin : monitor
    int n, m;
    bit rise, idle, e_wait, e_we;
    logic [7:0] lo, hi, old_rom, old_ram, t8;
    @(posedge clk_sys); #1;
    cyc++;
    n = cyc;

    if (ce_cpu && s_we) begin
      wr_count++;
      w_addr = s_addr;
      w_din  = s_din;
    end
    if (mem_we) run_len++;
    else begin
      if (s_we) last_len = run_len;
      run_len = 0;
    end
    s_we = mem_we; s_addr = mem_addr; s_din = mem_din;

    old_rom = m_rom; old_ram = m_ram;
    rise = ioctl_download && !m_prev_dl;
    idle = (n > m_busy_end);
    if (reset) begin
      m_busy_end = n; m_acc_t = 0; m_we_lo = 0; m_hi = 0;
      m_prev_dl = 0; m_seen = 0; m_ready = 0; m_ok = 0;
      m_mbc = 0; m_rom = 0; m_ram = 0; m_x = 0; m_rmask = 0; m_amask = 0;
      m_addr = 0; m_din = 0;
    end else begin
      m_rmask = exp_rom_mask(old_rom);
      m_amask = (old_ram == 8'd3) ? 2'b11 : 2'b00;
      if (rise) begin
        m_seen = 1; m_ready = 0; m_ok = 0;
        m_mbc = 0; m_rom = 0; m_ram = 0; m_x = 0; m_rmask = 0; m_amask = 0;
      end
      if (idle && ioctl_wr && ioctl_download) begin
        m = n + 1;
        while (!ce_at(m)) m++;
        m_acc_t = n; m_we_lo = m; m_hi = m + 8; m_busy_end = m + 8;
        m_addr = ioctl_addr[24:1];
        m_din  = ioctl_dout;
        lo = ioctl_dout[7:0];
        hi = ioctl_dout[15:8];
        if (ioctl_addr == 25'h146) m_mbc = hi;
        if (ioctl_addr == 25'h148) begin m_rom = lo; m_ram = hi; end
        if (ioctl_addr >= 25'h134 && ioctl_addr <= 25'h14A) m_x = m_x - lo - hi - 8'd2;
        if (ioctl_addr == 25'h14C) begin
          t8 = m_x - lo - 8'd1;
          m_ok = (t8 == hi);
        end
      end else if (idle && !ioctl_download && m_seen) begin
        m_ready = 1;
      end
      m_prev_dl = ioctl_download;
    end

    e_wait = (n >= m_acc_t) && (n < m_hi);
    e_we   = (n >= m_we_lo) && (n < m_hi);
    check("model_status",
          {ioctl_wait, mem_we, cart_ready, hdr_chk_ok, cart_mbc_type,
           cart_rom_size, cart_ram_size, rom_mask, ram_mask},
          {e_wait, e_we, m_ready, m_ok, m_mbc, m_rom, m_ram, m_rmask, m_amask});
    if (e_wait) check("model_mem_word", {mem_addr, mem_din}, {m_addr, m_din});
  end

  task automatic step(input int k = 1);
    repeat (k) begin @(posedge clk_sys); #2; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ioctl_wait && k < 40) begin step(); k++; end
    check("wait_bound", ioctl_wait, 1'b0);
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [15:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic send_word(input logic [24:0] a, input logic [15:0] d);
    pulse_wr(a, d);
    wait_idle();
  endtask

  function automatic logic [15:0] img_word(input int a, input int variant);
    if (variant == 0 && a == 'h146) return 16'h0300;
    if (variant == 0 && a == 'h148) return 16'h0305;
    if (variant == 1 && a == 'h14C) return 16'hE700;
    if (variant == 2 && a == 'h14C) return 16'hE600;
    if (a >= 'h134 && a <= 'h14C) return 16'h0000;
    return 16'((a * 'h0131) ^ 'h5A3C);
  endfunction

  task automatic load_image(input int first, input int last, input int variant);
    ioctl_download = 1'b1;
    step();
    for (int a = first; a <= last; a += 2) send_word(25'(a), img_word(a, variant));
    ioctl_download = 1'b0;
    step(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wc0, k;
    step(3);
    check("rst_ctrl", {ioctl_wait, mem_we, cart_ready, hdr_chk_ok}, 4'b0000);
    check("rst_mem", {mem_addr, mem_din}, 40'd0);
    check("rst_hdr", {cart_mbc_type, cart_rom_size, cart_ram_size, rom_mask, ram_mask}, 33'd0);
    reset = 1'b0;
    step();

    // single word
    ioctl_download = 1'b1;
    step();
    wc0 = wr_count;
    pulse_wr(25'h000010, 16'hBEEF);
    check("sw_wait_t1", ioctl_wait, 1'b1);
    check("sw_mem_addr", mem_addr, 24'h000008);
    check("sw_mem_din", mem_din, 16'hBEEF);
    wait_idle();
    check("sw_write_count", wr_count - wc0, 1);
    check("sw_write_word", {w_addr, w_din}, {24'h000008, 16'hBEEF});
    check("sw_we_len", last_len, 8);
    ioctl_download = 1'b0;
    step(2);

    // header capture over a full header image
    load_image('h0000, 'h014E, 0);
    check("hdr_mbc", cart_mbc_type, 8'h03);
    check("hdr_rom_size", cart_rom_size, 8'h05);
    check("hdr_ram_size", cart_ram_size, 8'h03);
    check("hdr_rom_mask", rom_mask, 7'h3F);
    check("hdr_ram_mask", ram_mask, 2'b11);
    check("hdr_chk_mixed", hdr_chk_ok, 1'b0);
    check("hdr_ready", cart_ready, 1'b1);

    // checksum good / bad
    load_image('h0100, 'h014E, 1);
    check("chk_good", hdr_chk_ok, 1'b1);
    check("chk_rom_mask_size0", rom_mask, 7'h01);
    load_image('h0100, 'h014E, 2);
    check("chk_bad", hdr_chk_ok, 1'b0);

    // download ends while the write is in flight
    ioctl_download = 1'b1;
    step();
    wc0 = wr_count;
    pulse_wr(25'h000148, 16'h0305);
    k = 0;
    while (!mem_we && k < 20) begin step(); k++; end
    check("dle_in_write", mem_we, 1'b1);
    ioctl_download = 1'b0;
    wait_idle();
    check("dle_ready_not_yet", cart_ready, 1'b0);
    check("dle_write_done", {32'(wr_count - wc0), w_din}, {32'd1, 16'h0305});
    step();
    check("dle_ready_rise", cart_ready, 1'b1);
    check("dle_rom_size", cart_rom_size, 8'h05);
    ioctl_download = 1'b1;
    step();
    check("dle_restart_clear",
          {cart_ready, hdr_chk_ok, cart_mbc_type, cart_rom_size, cart_ram_size, rom_mask, ram_mask},
          35'd0);

    // second ioctl_wr while busy is ignored
    wc0 = wr_count;
    pulse_wr(25'h000020, 16'h1111);
    pulse_wr(25'h000022, 16'h2222);
    check("ill_word_held", {mem_addr, mem_din}, {24'h000010, 16'h1111});
    wait_idle();
    check("ill_write_count", wr_count - wc0, 1);
    check("ill_write_word", {w_addr, w_din}, {24'h000010, 16'h1111});
    step(10);
    check("ill_no_second", {32'(wr_count - wc0), 1'b0, ioctl_wait, mem_we}, {32'd1, 3'b000});

    // reset held for 3 cycles in the middle of PEND
    k = 0;
    while (((cyc + 1) % 8) != 0 && k < 16) begin step(); k++; end
    wc0 = wr_count;
    pulse_wr(25'h000030, 16'hCAFE);
    check("rp_pend_wait", {ioctl_wait, mem_we}, 2'b10);
    step();
    reset = 1'b1;
    step(3);
    check("rp_outputs_zero",
          {ioctl_wait, mem_we, cart_ready, hdr_chk_ok, mem_addr, mem_din,
           cart_mbc_type, cart_rom_size, cart_ram_size, rom_mask, ram_mask},
          77'd0);
    reset = 1'b0;
    step(20);
    check("rp_no_write", wr_count - wc0, 0);
    send_word(25'h000040, 16'h4444);
    check("rp_idle_again", {32'(wr_count - wc0), w_addr, w_din}, {32'd1, 24'h000020, 16'h4444});

    ioctl_download = 1'b0;
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
